// File: rtl/rv32i_alu_sched.sv
// rv32i_alu_sched: shares one registered ALU between two requesters.
// Port 0 is the core execute stage, port 1 an auxiliary client.
// Sequence per op: IDLE (accept) -> ISSUE (strobe ALU) -> CAPTURE (latch y) -> RESP.
// Optional macro ALU_SCHED_PERF_EN adds grant/stall performance counters.
module rv32i_alu_sched #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned OP_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req_op0,
  input  logic [OP_W-1:0] req_op1,
  input  logic [31:0]     req_a0,
  input  logic [31:0]     req_b0,
  input  logic [31:0]     req_a1,
  input  logic [31:0]     req_b1,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [31:0]     resp_data,
  output logic            resp_err,
  output logic            alu,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic            alu_add,
  output logic            alu_sub,
  output logic            alu_slt,
  output logic            alu_sltu,
  output logic            alu_xor,
  output logic            alu_or,
  output logic            alu_and,
  output logic            alu_sll,
  output logic            alu_srl,
  output logic            alu_sra,
  output logic            alu_eq,
  output logic            alu_neq,
  output logic            alu_ge,
  output logic            alu_geu,
  input  logic [31:0]     alu_y
`ifdef ALU_SCHED_PERF_EN
  ,
  input  logic            perf_clr,
  output logic [31:0]     perf_grant0,
  output logic [31:0]     perf_grant1,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                sel;
  logic                accept;
  logic [OP_W-1:0]     sel_op;
  logic                sel_legal;
  logic [NUM_OPS-1:0]  sel_strobe;
  logic [NUM_OPS-1:0]  strobe_q;
  logic                illegal_q;
  logic                owner_q;
  logic                last_grant;

  // Arbitration: pick a port, then accept it only when idle and it is valid
  always_comb begin
    sel = 1'b0;
    if (ARB_MODE == 1) begin
      sel = ~req_valid[0] & req_valid[1];
    end else if (&req_valid) begin
      sel = ~last_grant;
    end else begin
      sel = req_valid[1];
    end
    sel_op     = sel ? req_op1 : req_op0;
    sel_legal  = (sel_op < OP_W'(NUM_OPS));
    sel_strobe = sel_legal ? (NUM_OPS'(1) << sel_op) : '0;
    accept     = rst_n && (state == IDLE) && req_valid[sel];
    req_ready      = 2'b00;
    req_ready[sel] = accept;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (resp_ready[owner_q]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latched request, registered ALU controls and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu        <= 1'b0;
      strobe_q   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      illegal_q  <= 1'b0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Strobes live for the single ISSUE cycle that follows an accept
      alu      <= 1'b0;
      strobe_q <= '0;
      if (accept) begin
        alu        <= sel_legal;
        strobe_q   <= sel_strobe;
        alu_a      <= sel ? req_a1 : req_a0;
        alu_b      <= sel ? req_b1 : req_b0;
        illegal_q  <= ~sel_legal;
        owner_q    <= sel;
        last_grant <= sel;
      end
      if (state == CAPTURE) begin
        resp_data  <= illegal_q ? DATA_W'(0) : alu_y;
        resp_err   <= illegal_q;
        resp_valid <= owner_q ? 2'b10 : 2'b01;
      end
      if ((state == RESP) && resp_ready[owner_q]) begin
        resp_valid <= 2'b00;
        resp_err   <= 1'b0;
      end
    end
  end

  assign {alu_geu, alu_ge, alu_neq, alu_eq, alu_sra, alu_srl, alu_sll,
          alu_and, alu_or, alu_xor, alu_sltu, alu_slt, alu_sub, alu_add} = strobe_q;

`ifdef ALU_SCHED_PERF_EN
  // Performance counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && !sel) perf_grant0 <= perf_grant0 + 32'd1;
      if (accept && sel)  perf_grant1 <= perf_grant1 + 32'd1;
      if (|(req_valid & ~req_ready)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
